fetch_queue: RTL
================

# fetch_queue

Parametrised fetch-stage buffer between instruction memory and decode. It holds up to DEPTH fetched instructions, each with its PC and branch ID, and presents them in order to decode with a valid/stall handshake. A branch redirect empties it in one cycle. It decouples fetch from decode stalls and is the deeper, registered-output generalisation of the single-entry fetch register.

## Interface
Parameters:
- WORD, 32, instruction width in bits
- ADDR, 32, PC width in bits
- W_BRID, 4, branch ID width in bits
- DEPTH, 4, entry count; power of two, ≥2
- W_CNT, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- v_i  in  1  fetch presents a valid instruction this cycle
- inst_i  in  WORD  fetched instruction
- pc_i  in  ADDR  PC of inst_i
- brid_i  in  W_BRID  branch ID tagged to inst_i
- stall_o  out  1  queue cannot accept; fetch must hold inst_i/pc_i/brid_i
- branch_i  in  1  redirect/flush request
- v_o  out  1  head entry valid
- inst_o  out  WORD  head instruction
- pc_o  out  ADDR  head PC
- brid_o  out  W_BRID  head branch ID
- stall_i  in  1  decode not accepting head this cycle
- count_o  out  W_CNT  current occupancy, 0..DEPTH

## Operation
- State: storage array of DEPTH entries {inst, pc, brid}, rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (W_CNT bits).
- full = (count == DEPTH); empty = (count == 0).
- pop = v_o & ~stall_i.
- push = v_i & (~full | pop); on a full queue, a same-cycle pop frees the slot.
- stall_o = full & ~pop. This is combinational from stall_i, intentionally, as in the single-entry stage.
- v_o = ~empty. inst_o/pc_o/brid_o = storage[rd_ptr]. These are driven from registers; there is no input-to-output bypass.
- Per cycle with no branch_i:
  - push writes storage[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - count += push − pop.
- Flush: branch_i = 1 has highest priority. On the next edge, count ← 0, rd_ptr ← 0, wr_ptr ← 0, and any push in that cycle is dropped, since the fetched instruction belongs to the wrong path.
  - Storage contents are not cleared, so inst_o/pc_o/brid_o hold stale values while v_o = 0.
  - stall_o is still computed as above during a flush cycle; fetch re-presents from the new PC afterwards.
- Reset (async, low):
  - rd_ptr, wr_ptr and count are set to 0, so v_o = 0, count_o = 0 and stall_o = 0.
  - All storage is cleared to 0, so inst_o = 0, pc_o = 0 and brid_o = 0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Latency: an instruction pushed at edge N appears at the head at edge N+1 if the queue was empty (v_o high one cycle after v_i).
- Throughput: one push and one pop per cycle sustained at any occupancy, including full.
- Empty with push and stall_i = 1: count 0→1, no pop (v_o was 0).
- Full with stall_i = 1: stall_o = 1, the push is ignored, and fetch must hold its inputs stable until stall_o = 0.
- Full with stall_i = 0: pop and push occur together, count stays at DEPTH, stall_o = 0.
- Pointer wrap: from DEPTH−1 to 0, with no gap in ordering.
- branch_i together with pop: the pop is irrelevant; count becomes 0 next cycle.
- count never exceeds DEPTH and never underflows.

## Test plan
- Fill/drain, DEPTH=4: push PCs 0x100, 0x104, 0x108, 0x10C with stall_i = 1.
  - count_o goes 1,2,3,4; stall_o = 1 after the fourth push; a fifth push of 0x110 is held.
  - Release stall_i: heads appear as 0x100, 0x104, 0x108, 0x10C, then 0x110, all in order.
- Full simultaneous: at count = 4, drive v_i = 1 and stall_i = 0 for 8 cycles.
  - count_o stays at 4 and stall_o stays 0.
  - Output PCs follow input order across pointer wrap.
- Flush: with 3 entries queued, assert branch_i for one cycle while v_i = 1 with pc_i = 0x200.
  - Next cycle: v_o = 0, count_o = 0, and 0x200 is never output.
  - Push 0x300: it appears at the head one cycle later with brid_o matching brid_i.
- Empty latency: push 0x40 into an empty queue with stall_i = 0.
  - v_o = 1 and pc_o = 0x40 exactly one cycle later; count_o returns to 0 after the pop.
- Reset mid-operation: with count = 2, pull reset low between clock edges.
  - v_o, count_o, stall_o, inst_o, pc_o and brid_o all go to 0 immediately.
  - After release, the first push 0x500 appears at the head.
- Randomised stall_i/v_i/branch_i against a scoreboard model: no loss, no duplication, in-order delivery, and no entry older than the last flush is delivered.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order fetch buffer between instruction memory and decode.
// Holds up to DEPTH {inst, pc, brid} entries. The head is driven from registers, and a branch flushes the queue.
module fetch_queue #(
    parameter int unsigned WORD   = 32,
    parameter int unsigned ADDR   = 32,
    parameter int unsigned W_BRID = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned W_CNT  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_i,
    input  logic [WORD-1:0]   inst_i,
    input  logic [ADDR-1:0]   pc_i,
    input  logic [W_BRID-1:0] brid_i,
    output logic              stall_o,
    input  logic              branch_i,
    output logic              v_o,
    output logic [WORD-1:0]   inst_o,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_BRID-1:0] brid_o,
    input  logic              stall_i,
    output logic [W_CNT-1:0]  count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [W_CNT-1:0] FULL_CNT = W_CNT'(DEPTH);

    logic [WORD-1:0]   mem_inst [DEPTH];
    logic [ADDR-1:0]   mem_pc   [DEPTH];
    logic [W_BRID-1:0] mem_brid [DEPTH];

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [W_CNT-1:0] count;

    logic full;
    logic empty;
    logic pop;
    logic push;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = v_o & ~stall_i;
    // A pop in the same cycle frees the slot, so a full queue still accepts a push.
    assign push  = v_i & (~full | pop);

    assign stall_o = full & ~pop;
    assign v_o     = ~empty;
    assign inst_o  = mem_inst[rd_ptr];
    assign pc_o    = mem_pc[rd_ptr];
    assign brid_o  = mem_brid[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
                mem_brid[i] <= '0;
            end
        end else if (branch_i) begin
            // Any wrong-path push in this cycle is dropped. The stale storage contents are left in place.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_inst[wr_ptr] <= inst_i;
                mem_pc[wr_ptr]   <= pc_i;
                mem_brid[wr_ptr] <= brid_i;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
